decimal_keypad_debouncer: RTL

Front-end for the decimal key inputs. It synchronizes 10 raw, bouncing key lines (digits 0-9) and debounces them as one vector. It outputs a clean, registered 10-bit vector that drives the decimal-to-priority encoder directly downstream. It also generates one-cycle press and release strobes for digit-entry logic.

---
 rtl/decimal_keypad_pkg.sv | 18 +
 rtl/sync_2ff.sv | 29 ++
 rtl/decimal_keypad_debouncer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/decimal_keypad_pkg.sv
// rtl/decimal_keypad_pkg.sv - shared types and helpers for the decimal keypad debouncer
// Purpose: key vector width, FSM state type, counter width helper.
// Ports: none (package).
package decimal_keypad_pkg;

  localparam int KEY_W = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  // Width of a counter that must reach cycles-1; never narrower than 1 bit.
  function automatic int cnt_w(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for an asynchronous vector
// Purpose: brings asynchronous lines into the clk domain.
// Ports:
//   clk   - sampling clock
//   rst_n - asynchronous active-low reset, clears both stages to 0
//   din   - asynchronous input vector
//   dout  - synchronized vector, two clk edges behind din
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      dout <= '0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/decimal_keypad_debouncer.sv
// rtl/decimal_keypad_debouncer.sv - synchronizes and debounces 10 decimal key lines
// Purpose: clean registered key vector plus one-cycle press/release strobes.
// Ports:
//   clk            - clock, all state changes on the rising edge
//   rst_n          - asynchronous active-low reset
//   key_raw[9:0]   - raw bouncing key lines, bit i = digit i, 1 = pressed
//   d[9:0]         - debounced key vector for the downstream encoder
//   valid          - d is nonzero
//   press          - one-cycle strobe when a key press is accepted
//   release_strobe - one-cycle strobe when d returns to zero
//                    ("release" is a reserved word, hence the longer name)
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-assert press every
// REPEAT_CYCLES cycles while a nonzero d is held unchanged.
module decimal_keypad_debouncer
  import decimal_keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_raw,
  output logic [KEY_W-1:0] d,
  output logic             valid,
  output logic             press,
  output logic             release_strobe
);

  localparam int              CNT_W   = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("decimal_keypad_debouncer: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  logic [KEY_W-1:0] s;
  logic [KEY_W-1:0] cand;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             repeat_due;
  state_t           state;
  state_t           state_next;
  logic             press_next;
  logic             release_next;

  sync_2ff #(.WIDTH(KEY_W)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (key_raw),
    .dout  (s)
  );

  // Accept wins over a simultaneous change of s: the settled candidate goes
  // out first and the new value opens its window on the following edge.
  assign accept = (cnt == CNT_MAX) && (cand != d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= '0;
      cnt  <= '0;
      d    <= '0;
    end else if (accept) begin
      d <= cand;
    end else if (s != cand) begin
      cand <= s;
      cnt  <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int              RPT_W   = cnt_w(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt;

  // Phase is zero on the edge d takes a new nonzero value, so the wrap
  // lands exactly REPEAT_CYCLES edges after the press or rollover.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt <= '0;
    end else if (state != ST_HELD || accept || rpt == RPT_MAX) begin
      rpt <= '0;
    end else begin
      rpt <= rpt + 1'b1;
    end
  end

  assign repeat_due = (state == ST_HELD) && !accept && (rpt == RPT_MAX);
`else
  assign repeat_due = 1'b0;
`endif

  always_comb begin
    state_next   = state;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && cand != '0) begin
          state_next = ST_HELD;
          press_next = 1'b1;
        end
      end
      ST_HELD: begin
        if (accept) begin
          // A nonzero cand here is a rollover: d changes, no strobe.
          if (cand == '0) begin
            state_next   = ST_IDLE;
            release_next = 1'b1;
          end
        end else if (repeat_due) begin
          press_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      press          <= 1'b0;
      release_strobe <= 1'b0;
    end else begin
      state          <= state_next;
      press          <= press_next;
      release_strobe <= release_next;
    end
  end

  assign valid = |d;

endmodule
